// File: rtl/cmos_dvp_pkg.sv
// Shared definitions for the DVP/RGB565 sensor-side transmitter.
package cmos_dvp_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_VSYNC   = 3'd1,
      ST_V_BACK  = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_V_FRONT = 3'd4
   } dvp_state_t;

   // RGB565 field widths
   localparam int R_W    = 5;
   localparam int G_W    = 6;
   localparam int B_W    = 5;
   localparam int PIX_W  = R_W + G_W + B_W;
   localparam int BYTE_W = 8;

   // Default OV5640-style VGA timing
   localparam int DEF_H_ACTIVE  = 640;
   localparam int DEF_V_ACTIVE  = 480;
   localparam int DEF_H_BLANK   = 144;
   localparam int DEF_VSYNC_LEN = 4;
   localparam int DEF_V_BACK    = 8;
   localparam int DEF_V_FRONT   = 4;

endpackage

// File: rtl/cmos_dvp_tx_timing_gen.sv
// Frame/line timing for the DVP transmitter: byte and line counters,
// the frame sequencer, and the vsync/href/frame-boundary flags.
module dvp_timing_gen
   import cmos_dvp_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int H_BLANK   = DEF_H_BLANK,
   parameter int VSYNC_LEN = DEF_VSYNC_LEN,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int V_FRONT   = DEF_V_FRONT,
   localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK,
   localparam int FRAME_LNS = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT,
   localparam int H_W       = $clog2(LINE_LEN),
   localparam int V_W       = $clog2(FRAME_LNS)
) (
   input  logic           clk_cmos,
   input  logic           rst,
   input  logic           tx_en,
   output logic           vsync,
   output logic           href,
   output logic           frame_start,
   output logic           frame_end,
   output logic [H_W-1:0] h_cnt,
   output logic [V_W-1:0] v_cnt
);

   dvp_state_t     state_r, state_nxt_s;
   logic [H_W-1:0] h_cnt_r, h_nxt_s;
   logic [V_W-1:0] v_cnt_r, v_nxt_s;
   logic           line_end_s;

   assign line_end_s  = (h_cnt_r == H_W'(LINE_LEN - 1));
   assign frame_end   = (state_r == ST_V_FRONT) && line_end_s &&
                        (v_cnt_r == V_W'(FRAME_LNS - 1));
   assign frame_start = tx_en && ((state_r == ST_IDLE) || frame_end);
   assign vsync       = (state_r == ST_VSYNC);
   assign href        = (state_r == ST_ACTIVE) && (h_cnt_r < H_W'(2 * H_ACTIVE));
   assign h_cnt       = h_cnt_r;
   assign v_cnt       = v_cnt_r;

   // State and counter registers; reset aborts any frame in progress
   always_ff @(posedge clk_cmos) begin
      if (rst) begin
         state_r <= ST_IDLE;
         h_cnt_r <= '0;
         v_cnt_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         h_cnt_r <= h_nxt_s;
         v_cnt_r <= v_nxt_s;
      end
   end

   // Next-state and counter advance; a frame always runs to its last line
   always_comb begin
      state_nxt_s = state_r;
      h_nxt_s     = h_cnt_r;
      v_nxt_s     = v_cnt_r;
      if (state_r == ST_IDLE) begin
         h_nxt_s = '0;
         v_nxt_s = '0;
      end else if (line_end_s) begin
         h_nxt_s = '0;
         v_nxt_s = v_cnt_r + V_W'(1);
      end else begin
         h_nxt_s = h_cnt_r + H_W'(1);
      end
      case (state_r)
         ST_IDLE: begin
            if (tx_en) state_nxt_s = ST_VSYNC;
            else       state_nxt_s = ST_IDLE;
         end
         ST_VSYNC: begin
            if (line_end_s && (v_cnt_r == V_W'(VSYNC_LEN - 1))) state_nxt_s = ST_V_BACK;
            else                                                 state_nxt_s = ST_VSYNC;
         end
         ST_V_BACK: begin
            if (line_end_s && (v_cnt_r == V_W'(VSYNC_LEN + V_BACK - 1))) state_nxt_s = ST_ACTIVE;
            else                                                          state_nxt_s = ST_V_BACK;
         end
         ST_ACTIVE: begin
            if (line_end_s && (v_cnt_r == V_W'(VSYNC_LEN + V_BACK + V_ACTIVE - 1)))
               state_nxt_s = ST_V_FRONT;
            else
               state_nxt_s = ST_ACTIVE;
         end
         ST_V_FRONT: begin
            if (frame_end) begin
               v_nxt_s = '0;
               if (tx_en) state_nxt_s = ST_VSYNC;
               else       state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_V_FRONT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            h_nxt_s     = '0;
            v_nxt_s     = '0;
         end
      endcase
   end

endmodule

// File: rtl/cmos_dvp_tx.sv
// DVP/RGB565 sensor emulator: serialises 16-bit pixels (upstream stream or
// coordinate test pattern) into an OV5640-style vsync/href/byte stream.
module cmos_dvp_tx
   import cmos_dvp_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int H_BLANK   = DEF_H_BLANK,
   parameter int VSYNC_LEN = DEF_VSYNC_LEN,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int V_FRONT   = DEF_V_FRONT
) (
   input  logic              clk_cmos,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              pattern_sel,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              cmos_vsync,
   output logic              cmos_href,
   output logic [BYTE_W-1:0] cmos_dout,
   output logic [15:0]       frame_cnt,
   output logic              underflow
);

   localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int FRAME_LNS = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_W       = $clog2(LINE_LEN);
   localparam int V_W       = $clog2(FRAME_LNS);

   logic              vsync_s, href_s, frame_start_s, frame_end_s;
   logic [H_W-1:0]    h_cnt_s;
   logic [V_W-1:0]    v_cnt_s;
   logic              pattern_r;
   logic [BYTE_W-1:0] lo_byte_r;
   logic              underflow_r;
   logic [15:0]       frame_cnt_r;
   logic [PIX_W-1:0]  pixel_s;
   logic [7:0]        pat_x_s, pat_y_s;
   logic              take_s, pix_ready_s;
   logic [BYTE_W-1:0] dout_s;

   dvp_timing_gen #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .H_BLANK   (H_BLANK),
      .VSYNC_LEN (VSYNC_LEN),
      .V_BACK    (V_BACK),
      .V_FRONT   (V_FRONT)
   ) u_timing (
      .clk_cmos    (clk_cmos),
      .rst         (rst),
      .tx_en       (tx_en),
      .vsync       (vsync_s),
      .href        (href_s),
      .frame_start (frame_start_s),
      .frame_end   (frame_end_s),
      .h_cnt       (h_cnt_s),
      .v_cnt       (v_cnt_s)
   );

   // A pixel is fetched on every even active byte; upstream is only asked in stream mode
   assign take_s      = href_s & ~h_cnt_s[0];
   assign pix_ready_s = take_s & ~pattern_r;

   // Pixel source: coordinate pattern, upstream data, or zero on starvation
   always_comb begin
      pat_x_s = 8'(h_cnt_s >> 1);
      pat_y_s = 8'(v_cnt_s - V_W'(VSYNC_LEN + V_BACK));
      if (pattern_r)      pixel_s = {pat_y_s, pat_x_s};
      else if (pix_valid) pixel_s = pix_data;
      else                pixel_s = {PIX_W{1'b0}};
   end

   // Byte serialiser: high byte passes straight out, low byte comes from the holding register
   always_comb begin
      if (!href_s)          dout_s = 8'h00;
      else if (!h_cnt_s[0]) dout_s = pixel_s[15:8];
      else                  dout_s = lo_byte_r;
   end

   // Frame-held mode select, low-byte holding register, sticky underflow and frame counter
   always_ff @(posedge clk_cmos) begin
      if (rst) begin
         pattern_r   <= 1'b0;
         lo_byte_r   <= 8'h00;
         underflow_r <= 1'b0;
         frame_cnt_r <= 16'h0000;
      end else begin
         if (frame_start_s) pattern_r <= pattern_sel;
         else               pattern_r <= pattern_r;
         if (take_s) lo_byte_r <= pixel_s[7:0];
         else        lo_byte_r <= lo_byte_r;
         if (pix_ready_s && !pix_valid) underflow_r <= 1'b1;
         else                           underflow_r <= underflow_r;
         if (frame_end_s) frame_cnt_r <= frame_cnt_r + 16'd1;
         else             frame_cnt_r <= frame_cnt_r;
      end
   end

   assign pix_ready  = pix_ready_s;
   assign cmos_vsync = vsync_s;
   assign cmos_href  = href_s;
   assign cmos_dout  = dout_s;
   assign frame_cnt  = frame_cnt_r;
   assign underflow  = underflow_r;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Self-checking bench for cmos_dvp_tx with a small timing (L=14, 84-clock frame).
module tb_cmos_dvp_tx;

   localparam int HA   = 4;
   localparam int VA   = 3;
   localparam int HB   = 6;
   localparam int VS   = 1;
   localparam int VB   = 1;
   localparam int VF   = 1;
   localparam int LL   = 2 * HA + HB;
   localparam int FR   = LL * (VS + VB + VA + VF);
   localparam int ACT0 = VS + VB;

   logic        clk_cmos = 1'b0;
   logic        rst, tx_en, pattern_sel, pix_valid;
   logic [15:0] pix_data;
   logic        pix_ready, cmos_vsync, cmos_href, underflow;
   logic [7:0]  cmos_dout;
   logic [15:0] frame_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] src_tbl [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hABCD};
   int          src_idx;
   bit          feed_on;

   cmos_dvp_tx #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
      .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF)
   ) dut (
      .clk_cmos    (clk_cmos),
      .rst         (rst),
      .tx_en       (tx_en),
      .pattern_sel (pattern_sel),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .cmos_vsync  (cmos_vsync),
      .cmos_href   (cmos_href),
      .cmos_dout   (cmos_dout),
      .frame_cnt   (frame_cnt),
      .underflow   (underflow)
   );

   always #5 clk_cmos = ~clk_cmos;

   function automatic logic model_href(input int k);
      int line, h;
      line = (k % FR) / LL;
      h    = k % LL;
      return (line >= ACT0) && (line < ACT0 + VA) && (h < 2 * HA);
   endfunction

   // Advance to the next negedge, answer a ready request, push expected bytes, settle
   task automatic tick(input bit drop);
      @(negedge clk_cmos);
      pix_valid = 1'b1;
      if (feed_on && pix_ready) begin
         if (drop) begin
            pix_valid = 1'b0;
            pix_data  = 16'h1234;
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
         end else begin
            pix_data = src_tbl[src_idx];
            exp_q.push_back(src_tbl[src_idx][15:8]);
            exp_q.push_back(src_tbl[src_idx][7:0]);
         end
         src_idx = (src_idx + 1) % 4;
      end
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; tx_en = 1'b0; pattern_sel = 1'b0;
      pix_valid = 1'b0; pix_data = 16'h0000;
      feed_on = 1'b0; src_idx = 0;
      exp_q.delete();
      repeat (3) @(negedge clk_cmos);
   endtask

   task automatic test_reset();
      apply_reset();
      tx_en = 1'b1;
      @(negedge clk_cmos); #1;
      n_checks += 6;
      if (cmos_vsync !== 1'b0) begin n_errors++; $display("FAIL reset_vsync: got %b expected 0", cmos_vsync); end
      if (cmos_href !== 1'b0)  begin n_errors++; $display("FAIL reset_href: got %b expected 0", cmos_href); end
      if (cmos_dout !== 8'h00) begin n_errors++; $display("FAIL reset_dout: got %h expected 00", cmos_dout); end
      if (pix_ready !== 1'b0)  begin n_errors++; $display("FAIL reset_ready: got %b expected 0", pix_ready); end
      if (underflow !== 1'b0)  begin n_errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
      if (frame_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt); end
   endtask

   task automatic test_timing_pattern();
      logic [7:0] line1 [8] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03};
      logic [7:0] got1 [8];
      apply_reset();
      pattern_sel = 1'b1; tx_en = 1'b1; rst = 1'b0;
      for (int k = 0; k < FR; k++) begin
         int line, h;
         logic e_vs, e_hr;
         logic [7:0] e_do;
         tick(1'b0);
         if (k == 40) pattern_sel = 1'b0;
         line = k / LL; h = k % LL;
         e_vs = (line < VS);
         e_hr = model_href(k);
         e_do = !e_hr ? 8'h00 : ((h % 2 == 0) ? 8'(line - ACT0) : 8'(h / 2));
         if (line == ACT0 + 1 && h < 2 * HA) got1[h] = cmos_dout;
         n_checks += 4;
         if (cmos_vsync !== e_vs) begin n_errors++; $display("FAIL tim_vsync k=%0d: got %b expected %b", k, cmos_vsync, e_vs); end
         if (cmos_href !== e_hr)  begin n_errors++; $display("FAIL tim_href k=%0d: got %b expected %b", k, cmos_href, e_hr); end
         if (cmos_dout !== e_do)  begin n_errors++; $display("FAIL pat_dout k=%0d: got %h expected %h", k, cmos_dout, e_do); end
         if (pix_ready !== 1'b0)  begin n_errors++; $display("FAIL pat_ready k=%0d: got %b expected 0", k, pix_ready); end
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (got1[i] !== line1[i]) begin n_errors++; $display("FAIL pat_line1 byte%0d: got %h expected %h", i, got1[i], line1[i]); end
      end
      tick(1'b0);
      n_checks += 2;
      if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL tim_frame_cnt: got %0d expected 1", frame_cnt); end
      if (cmos_vsync !== 1'b1) begin n_errors++; $display("FAIL tim_next_vsync: got %b expected 1", cmos_vsync); end
   endtask

   task automatic test_stream(input bit with_drop);
      int n_rdy, last_rdy;
      int k_drop;
      logic e_hr, e_rdy, e_uf;
      logic [7:0] e_do;
      apply_reset();
      pattern_sel = 1'b0; feed_on = 1'b1; tx_en = 1'b1; rst = 1'b0;
      n_rdy = 0; last_rdy = -10;
      k_drop = with_drop ? (ACT0 * LL + 4) : -1;
      for (int k = 0; k < FR; k++) begin
         int h;
         tick(k == k_drop);
         h     = k % LL;
         e_hr  = model_href(k);
         e_rdy = e_hr && (h % 2 == 0);
         e_uf  = with_drop && (k > k_drop);
         n_checks += 3;
         if (cmos_href !== e_hr)  begin n_errors++; $display("FAIL str_href k=%0d: got %b expected %b", k, cmos_href, e_hr); end
         if (pix_ready !== e_rdy) begin n_errors++; $display("FAIL str_ready k=%0d: got %b expected %b", k, pix_ready, e_rdy); end
         if (underflow !== e_uf)  begin n_errors++; $display("FAIL str_underflow k=%0d: got %b expected %b", k, underflow, e_uf); end
         if (pix_ready === 1'b1) begin
            n_rdy++;
            if (h != 0) begin
               n_checks++;
               if (k - last_rdy != 2) begin n_errors++; $display("FAIL str_ready_gap k=%0d: got %0d expected 2", k, k - last_rdy); end
            end
            last_rdy = k;
         end
         if (e_hr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++; $display("FAIL str_dout k=%0d: got %h expected none queued", k, cmos_dout);
            end else begin
               e_do = exp_q.pop_front();
               if (cmos_dout !== e_do) begin n_errors++; $display("FAIL str_dout k=%0d: got %h expected %h", k, cmos_dout, e_do); end
            end
         end else begin
            n_checks++;
            if (cmos_dout !== 8'h00) begin n_errors++; $display("FAIL str_blank_dout k=%0d: got %h expected 00", k, cmos_dout); end
         end
      end
      n_checks += 3;
      if (n_rdy != 4 * VA) begin n_errors++; $display("FAIL str_ready_count: got %0d expected %0d", n_rdy, 4 * VA); end
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL str_leftover: got %0d expected 0", exp_q.size()); end
      if (underflow !== with_drop) begin n_errors++; $display("FAIL str_final_underflow: got %b expected %b", underflow, with_drop); end
   endtask

   task automatic test_stop();
      int hr_cnt;
      apply_reset();
      pattern_sel = 1'b1; tx_en = 1'b1; rst = 1'b0;
      hr_cnt = 0;
      for (int k = 0; k < FR; k++) begin
         tick(1'b0);
         if (k == 35) tx_en = 1'b0;
         if (k >= 35 && cmos_href === 1'b1) hr_cnt++;
      end
      tick(1'b0);
      n_checks += 6;
      if (hr_cnt != 17)        begin n_errors++; $display("FAIL stop_href_rest: got %0d expected 17", hr_cnt); end
      if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL stop_frame_cnt: got %0d expected 1", frame_cnt); end
      if (cmos_vsync !== 1'b0) begin n_errors++; $display("FAIL stop_vsync: got %b expected 0", cmos_vsync); end
      if (cmos_href !== 1'b0)  begin n_errors++; $display("FAIL stop_href: got %b expected 0", cmos_href); end
      if (cmos_dout !== 8'h00) begin n_errors++; $display("FAIL stop_dout: got %h expected 00", cmos_dout); end
      if (pix_ready !== 1'b0)  begin n_errors++; $display("FAIL stop_ready: got %b expected 0", pix_ready); end
      repeat (2 * LL) tick(1'b0);
      n_checks += 2;
      if (cmos_vsync !== 1'b0) begin n_errors++; $display("FAIL stop_idle_vsync: got %b expected 0", cmos_vsync); end
      if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL stop_idle_frame_cnt: got %0d expected 1", frame_cnt); end
   endtask

   task automatic test_abort();
      apply_reset();
      pattern_sel = 1'b1; tx_en = 1'b1; rst = 1'b0;
      for (int k = 0; k <= FR + 44; k++) tick(1'b0);
      n_checks += 3;
      if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL abort_pre_frame_cnt: got %0d expected 1", frame_cnt); end
      if (cmos_href !== 1'b1)  begin n_errors++; $display("FAIL abort_pre_href: got %b expected 1", cmos_href); end
      if (cmos_dout !== 8'h01) begin n_errors++; $display("FAIL abort_pre_dout: got %h expected 01", cmos_dout); end
      rst = 1'b1;
      tick(1'b0);
      n_checks += 5;
      if (frame_cnt !== 16'd0) begin n_errors++; $display("FAIL abort_frame_cnt: got %0d expected 0", frame_cnt); end
      if (cmos_href !== 1'b0)  begin n_errors++; $display("FAIL abort_href: got %b expected 0", cmos_href); end
      if (cmos_vsync !== 1'b0) begin n_errors++; $display("FAIL abort_vsync: got %b expected 0", cmos_vsync); end
      if (cmos_dout !== 8'h00) begin n_errors++; $display("FAIL abort_dout: got %h expected 00", cmos_dout); end
      if (pix_ready !== 1'b0)  begin n_errors++; $display("FAIL abort_ready: got %b expected 0", pix_ready); end
      rst = 1'b0; tx_en = 1'b0;
      repeat (5) tick(1'b0);
      n_checks += 2;
      if (cmos_vsync !== 1'b0) begin n_errors++; $display("FAIL abort_idle_vsync: got %b expected 0", cmos_vsync); end
      if (frame_cnt !== 16'd0) begin n_errors++; $display("FAIL abort_idle_frame_cnt: got %0d expected 0", frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_timing_pattern();
      test_stream(1'b0);
      test_stream(1'b1);
      test_stop();
      test_abort();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
